// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - generic elastic pipeline stage register with flush and optional skid entry
//
// Purpose: inter-stage register for the pipelined CPU. Carries a packed DATA_W payload
// with a valid/ready handshake, a flush that inserts a bubble, and an optional second
// (skid) entry so that in_ready is driven from registered state only.
//
// Ports:
//   clk        in   1       clock, all state updates on posedge
//   reset      in   1       synchronous, active-high, highest priority
//   flush      in   1       discard held entries and any input this cycle
//   in_valid   in   1       upstream has a payload
//   in_ready   out  1       stage accepts a payload this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       stage presents a payload
//   out_ready  in   1       downstream accepts the payload this cycle
//   out_data   out  DATA_W  payload to downstream
//   occupancy  out  2       number of entries held
module pipe_stage_elastic #(
  parameter int DATA_W     = 32,
  parameter bit SKID       = 1'b1,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count; ST_ONE is the single FULL state when SKID=0.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = (state_q != ST_EMPTY) & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and payload steering
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer && SKID) begin
            // Downstream stalled: park the new payload behind the one on display.
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
            if (CLEAR_DATA) main_d = '0;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            if (CLEAR_DATA) skid_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_data  = main_q;
    occupancy = state_q;
    if (SKID) begin
      // Registered-state only: no path from out_ready to in_ready.
      in_ready = ~reset & ~flush & (state_q != ST_TWO);
    end else begin
      in_ready = ~reset & ~flush & ((state_q == ST_EMPTY) | out_ready);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic (SKID=1 and SKID=0)
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(32), .SKID(1'b1), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  pipe_stage_elastic #(.DATA_W(32), .SKID(1'b0), .CLEAR_DATA(1'b1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0)
  );

  // Reference model: each stage is a FIFO queue of bounded depth; an empty stage shows 0.
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs to the model for the current inputs, then advance the model.
  task automatic model_step();
    bit          ir1, ir0;
    logic [31:0] od1, od0;
    ir1 = !reset && !flush && (q1.size() < 2);
    ir0 = !reset && !flush && (q0.size() == 0 || out_ready);
    od1 = (q1.size() > 0) ? q1[0] : 32'h0;
    od0 = (q0.size() > 0) ? q0[0] : 32'h0;
    if (model_ok) begin
      chk("m1_in_ready",  in_ready1,  ir1);
      chk("m1_out_valid", out_valid1, q1.size() > 0);
      chk("m1_out_data",  out_data1,  od1);
      chk("m1_occupancy", occ1,       q1.size());
      chk("m0_in_ready",  in_ready0,  ir0);
      chk("m0_out_valid", out_valid0, q0.size() > 0);
      chk("m0_out_data",  out_data0,  od0);
      chk("m0_occupancy", occ0,       q0.size());
    end
    if (reset) begin
      q1.delete();
      q0.delete();
      model_ok = 1'b1;
    end else if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (in_valid && ir1) q1.push_back(in_data);
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (in_valid && ir0) q0.push_back(in_data);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit r, input bit f, input bit iv, input logic [31:0] d, input bit o);
    reset = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
  endtask

  typedef struct {
    bit          rst, fl, iv;
    logic [31:0] d;
    bit          ordy;
    bit          chk_all;
    bit          e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
    bit          e_ir;
  } vec_t;

  vec_t tbl[$];

  initial begin
    set_in(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

    //               rst fl iv data           ordy all ov od            occ   ir
    // reset held two cycles
    tbl.push_back('{1, 0, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        2'd0, 0});
    tbl.push_back('{1, 0, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0,        2'd0, 0});
    // stream 1..4 at full rate, then bubble
    tbl.push_back('{0, 0, 1, 32'd1,        1, 1, 0, 32'h0,        2'd0, 1});
    tbl.push_back('{0, 0, 1, 32'd2,        1, 1, 1, 32'd1,        2'd1, 1});
    tbl.push_back('{0, 0, 1, 32'd3,        1, 1, 1, 32'd2,        2'd1, 1});
    tbl.push_back('{0, 0, 1, 32'd4,        1, 1, 1, 32'd3,        2'd1, 1});
    tbl.push_back('{0, 0, 0, 32'd0,        1, 1, 1, 32'd4,        2'd1, 1});
    tbl.push_back('{0, 0, 0, 32'd0,        1, 1, 0, 32'h0,        2'd0, 1});
    // backpressure into the skid entry
    tbl.push_back('{0, 0, 1, 32'd1,        1, 1, 0, 32'h0,        2'd0, 1});
    tbl.push_back('{0, 0, 1, 32'd2,        1, 1, 1, 32'd1,        2'd1, 1});
    tbl.push_back('{0, 0, 1, 32'd3,        0, 1, 1, 32'd2,        2'd1, 1});
    tbl.push_back('{0, 0, 1, 32'd99,       0, 1, 1, 32'd2,        2'd2, 0});
    tbl.push_back('{0, 0, 0, 32'd0,        1, 1, 1, 32'd2,        2'd2, 0});
    tbl.push_back('{0, 0, 0, 32'd0,        1, 1, 1, 32'd3,        2'd1, 1});
    tbl.push_back('{0, 0, 0, 32'd0,        0, 1, 0, 32'h0,        2'd0, 1});
    // flush at occupancy 2 with input 9 offered
    tbl.push_back('{0, 0, 1, 32'd5,        0, 1, 0, 32'h0,        2'd0, 1});
    tbl.push_back('{0, 0, 1, 32'd6,        0, 1, 1, 32'd5,        2'd1, 1});
    tbl.push_back('{0, 1, 1, 32'd9,        0, 1, 1, 32'd5,        2'd2, 0});
    tbl.push_back('{0, 0, 0, 32'd0,        1, 1, 0, 32'h0,        2'd0, 1});
    tbl.push_back('{0, 0, 0, 32'd0,        1, 1, 0, 32'h0,        2'd0, 1});
    // reset mid-stream at occupancy 1, out_ready low
    tbl.push_back('{0, 0, 1, 32'd8,        0, 1, 0, 32'h0,        2'd0, 1});
    tbl.push_back('{1, 0, 0, 32'd0,        0, 1, 1, 32'd8,        2'd1, 0});
    tbl.push_back('{0, 0, 1, 32'd5,        0, 1, 0, 32'h0,        2'd0, 1});
    tbl.push_back('{0, 0, 0, 32'd0,        0, 1, 1, 32'd5,        2'd1, 1});

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), in_ready1, tbl[i].e_ir);
      if (tbl[i].chk_all) begin
        chk($sformatf("tbl%0d_out_valid", i), out_valid1, tbl[i].e_ov);
        chk($sformatf("tbl%0d_out_data", i),  out_data1,  tbl[i].e_od);
        chk($sformatf("tbl%0d_occupancy", i), occ1,       tbl[i].e_occ);
      end
      tick();
    end

    // SKID=0: combinational ready follows out_ready when full
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk); tick();
    set_in(1'b0, 1'b0, 1'b1, 32'd3, 1'b0);
    @(negedge clk);
    chk("s0_ready_empty", in_ready0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'd4, 1'b0);
    @(negedge clk);
    chk("s0_ready_stalled", in_ready0, 1'b0);
    chk("s0_data_held", out_data0, 32'd3);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'd7, 1'b1);
    @(negedge clk);
    chk("s0_ready_release", in_ready0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    chk("s0_data_7", out_data0, 32'd7);
    chk("s0_valid_7", out_valid0, 1'b1);
    tick();

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
      @(negedge clk);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
